// File: rtl/hazard_controller_if.sv
// Control bundle between the decode/pipeline datapath and the hazard controller.
// The controller side uses the slave modport; the datapath side uses master.
interface hazard_controller_if #(
    parameter int CNT_W = 16
);
    // DOF-stage decoded fields and stage status
    logic [4:0]       DA;
    logic [4:0]       AA;
    logic [4:0]       BA;
    logic             RW;
    logic             MA;
    logic             MB;
    logic             br_taken;
    logic             mem_busy;
    // Pipeline register controls
    logic             pc_hold;
    logic             ir_hold;
    logic             ir_nop;
    logic             ex_hold;
    logic             ex_nop;
    // Status
    logic [1:0]       last_action;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] squash_cnt;

    modport slave (
        input  DA, AA, BA, RW, MA, MB, br_taken, mem_busy,
        output pc_hold, ir_hold, ir_nop, ex_hold, ex_nop,
        output last_action, stall_cnt, squash_cnt
    );

    modport master (
        output DA, AA, BA, RW, MA, MB, br_taken, mem_busy,
        input  pc_hold, ir_hold, ir_nop, ex_hold, ex_nop,
        input  last_action, stall_cnt, squash_cnt
    );
endinterface

// File: rtl/hazard_controller.sv
// Hazard controller for the 4-stage IF/DOF/EX/WB core without forwarding.
// Tracks the destinations in flight in EX and WB, and picks one action per
// cycle with priority FREEZE > SQUASH > STALL > RUN.
module hazard_controller #(
    parameter bit WB_BYPASS   = 1'b0,
    parameter bit ZERO_REG_EN = 1'b1,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    hazard_controller_if.slave  hif
);

    typedef enum logic [1:0] {
        ACT_RUN    = 2'd0,
        ACT_STALL  = 2'd1,
        ACT_SQUASH = 2'd2,
        ACT_FREEZE = 2'd3
    } action_e;

    logic             ex_rw_q, ex_rw_d;
    logic [4:0]       ex_da_q, ex_da_d;
    logic             wb_rw_q, wb_rw_d;
    logic [4:0]       wb_da_q, wb_da_d;
    action_e          last_q, last_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;

    logic             a_rd, b_rd, hazard;
    action_e          action;

    // A scoreboard entry blocks a read only if it really writes a non-zero register
    function automatic logic stage_match(input logic rw, input logic [4:0] da,
                                         input logic [4:0] src);
        return rw && !(ZERO_REG_EN && (da == 5'd0)) && (da == src);
    endfunction

    // RAW detection against EX (and WB unless the register file bypasses) and action select
    always_comb begin
        a_rd   = !hif.MA && !(ZERO_REG_EN && (hif.AA == 5'd0));
        b_rd   = !hif.MB && !(ZERO_REG_EN && (hif.BA == 5'd0));
        hazard = (a_rd && (stage_match(ex_rw_q, ex_da_q, hif.AA) ||
                           (!WB_BYPASS && stage_match(wb_rw_q, wb_da_q, hif.AA)))) ||
                 (b_rd && (stage_match(ex_rw_q, ex_da_q, hif.BA) ||
                           (!WB_BYPASS && stage_match(wb_rw_q, wb_da_q, hif.BA))));
        // A taken branch makes the DOF instruction wrong-path, so its hazard is moot
        if (hif.mem_busy)      action = ACT_FREEZE;
        else if (hif.br_taken) action = ACT_SQUASH;
        else if (hazard)       action = ACT_STALL;
        else                   action = ACT_RUN;
    end

    // Decode the selected action into pipeline register controls
    always_comb begin
        hif.pc_hold = 1'b0;
        hif.ir_hold = 1'b0;
        hif.ir_nop  = 1'b0;
        hif.ex_hold = 1'b0;
        hif.ex_nop  = 1'b0;
        case (action)
            ACT_FREEZE: begin
                hif.pc_hold = 1'b1;
                hif.ir_hold = 1'b1;
                hif.ex_hold = 1'b1;
            end
            ACT_SQUASH: begin
                hif.ir_nop = 1'b1;
                hif.ex_nop = 1'b1;
            end
            ACT_STALL: begin
                hif.pc_hold = 1'b1;
                hif.ir_hold = 1'b1;
                hif.ex_nop  = 1'b1;
            end
            default: ;
        endcase
    end

    // Scoreboard advance, action record and saturating counters
    always_comb begin
        ex_rw_d      = ex_rw_q;
        ex_da_d      = ex_da_q;
        wb_rw_d      = wb_rw_q;
        wb_da_d      = wb_da_q;
        stall_cnt_d  = stall_cnt_q;
        squash_cnt_d = squash_cnt_q;
        last_d       = action;
        case (action)
            ACT_FREEZE: ;
            ACT_SQUASH, ACT_STALL: begin
                // A bubble enters EX while the old EX entry moves on to WB
                wb_rw_d = ex_rw_q;
                wb_da_d = ex_da_q;
                ex_rw_d = 1'b0;
                ex_da_d = 5'd0;
                if (action == ACT_STALL) begin
                    if (stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + CNT_W'(1);
                end else begin
                    if (squash_cnt_q != {CNT_W{1'b1}}) squash_cnt_d = squash_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                wb_rw_d = ex_rw_q;
                wb_da_d = ex_da_q;
                ex_rw_d = hif.RW;
                ex_da_d = hif.DA;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_rw_q      <= 1'b0;
            ex_da_q      <= 5'd0;
            wb_rw_q      <= 1'b0;
            wb_da_q      <= 5'd0;
            last_q       <= ACT_RUN;
            stall_cnt_q  <= '0;
            squash_cnt_q <= '0;
        end else begin
            ex_rw_q      <= ex_rw_d;
            ex_da_q      <= ex_da_d;
            wb_rw_q      <= wb_rw_d;
            wb_da_q      <= wb_da_d;
            last_q       <= last_d;
            stall_cnt_q  <= stall_cnt_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign hif.last_action = last_q;
    assign hif.stall_cnt   = stall_cnt_q;
    assign hif.squash_cnt  = squash_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: three configurations driven by the same
// directed instruction vectors, each checked every cycle against a model of
// the in-flight writers, plus literal expectations from the test plan.
module tb_hazard_controller;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Config 0: no bypass, R0 zero, 16-bit counters
    // Config 1: WB bypass, R0 zero, 16-bit counters
    // Config 2: no bypass, R0 ordinary, 3-bit counters (saturation)
    hazard_controller_if #(.CNT_W(16)) hif0 ();
    hazard_controller_if #(.CNT_W(16)) hif1 ();
    hazard_controller_if #(.CNT_W(3))  hif2 ();

    hazard_controller #(.WB_BYPASS(1'b0), .ZERO_REG_EN(1'b1), .CNT_W(16))
        u_dut0 (.clk(clk), .rst(rst), .hif(hif0));
    hazard_controller #(.WB_BYPASS(1'b1), .ZERO_REG_EN(1'b1), .CNT_W(16))
        u_dut1 (.clk(clk), .rst(rst), .hif(hif1));
    hazard_controller #(.WB_BYPASS(1'b0), .ZERO_REG_EN(1'b0), .CNT_W(3))
        u_dut2 (.clk(clk), .rst(rst), .hif(hif2));

    logic [4:0] s_da, s_aa, s_ba;
    logic       s_rw, s_ma, s_mb, s_br, s_busy;

    assign hif0.DA = s_da; assign hif0.AA = s_aa; assign hif0.BA = s_ba; assign hif0.RW = s_rw;
    assign hif0.MA = s_ma; assign hif0.MB = s_mb; assign hif0.br_taken = s_br; assign hif0.mem_busy = s_busy;
    assign hif1.DA = s_da; assign hif1.AA = s_aa; assign hif1.BA = s_ba; assign hif1.RW = s_rw;
    assign hif1.MA = s_ma; assign hif1.MB = s_mb; assign hif1.br_taken = s_br; assign hif1.mem_busy = s_busy;
    assign hif2.DA = s_da; assign hif2.AA = s_aa; assign hif2.BA = s_ba; assign hif2.RW = s_rw;
    assign hif2.MA = s_ma; assign hif2.MB = s_mb; assign hif2.br_taken = s_br; assign hif2.mem_busy = s_busy;

    // Observed outputs; control vector is {pc_hold, ir_hold, ir_nop, ex_hold, ex_nop}
    logic [4:0] ctl [3];
    int         la [3];
    int         sc [3];
    int         qc [3];
    assign ctl[0] = {hif0.pc_hold, hif0.ir_hold, hif0.ir_nop, hif0.ex_hold, hif0.ex_nop};
    assign ctl[1] = {hif1.pc_hold, hif1.ir_hold, hif1.ir_nop, hif1.ex_hold, hif1.ex_nop};
    assign ctl[2] = {hif2.pc_hold, hif2.ir_hold, hif2.ir_nop, hif2.ex_hold, hif2.ex_nop};
    assign la[0] = 32'(hif0.last_action); assign sc[0] = 32'(hif0.stall_cnt); assign qc[0] = 32'(hif0.squash_cnt);
    assign la[1] = 32'(hif1.last_action); assign sc[1] = 32'(hif1.stall_cnt); assign qc[1] = 32'(hif1.squash_cnt);
    assign la[2] = 32'(hif2.last_action); assign sc[2] = 32'(hif2.stall_cnt); assign qc[2] = 32'(hif2.squash_cnt);

    // ---------------- reference model ----------------
    bit BYP  [3] = '{1'b0, 1'b1, 1'b0};
    bit ZR   [3] = '{1'b1, 1'b1, 1'b0};
    int MAXC [3] = '{65535, 65535, 7};

    // Writers in flight, index 0 = one instruction ahead (EX), 1 = two ahead (WB)
    logic       m_rw [3][2];
    logic [4:0] m_da [3][2];
    int         m_last [3];
    int         m_st [3];
    int         m_sq [3];

    int  n_cmp = 0;
    int  n_err = 0;
    bit  chk_en = 1'b0;

    // Action the rules demand now: 0 RUN, 1 STALL, 2 SQUASH, 3 FREEZE
    function automatic int exp_act(input int k);
        bit a_rd, b_rd, hz;
        int depth;
        if (s_busy) return 3;
        if (s_br)   return 2;
        a_rd  = !s_ma && !(ZR[k] && s_aa == 5'd0);
        b_rd  = !s_mb && !(ZR[k] && s_ba == 5'd0);
        depth = BYP[k] ? 1 : 2;
        hz    = 1'b0;
        for (int d = 0; d < depth; d++) begin
            if (m_rw[k][d] && !(ZR[k] && m_da[k][d] == 5'd0)) begin
                if (a_rd && m_da[k][d] == s_aa) hz = 1'b1;
                if (b_rd && m_da[k][d] == s_ba) hz = 1'b1;
            end
        end
        return hz ? 1 : 0;
    endfunction

    function automatic logic [4:0] ctl_of(input int a);
        case (a)
            1:       return 5'b11001;
            2:       return 5'b00101;
            3:       return 5'b11010;
            default: return 5'b00000;
        endcase
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_rw[k][0] <= 1'b0; m_rw[k][1] <= 1'b0;
                m_da[k][0] <= 5'd0; m_da[k][1] <= 5'd0;
                m_last[k]  <= 0; m_st[k] <= 0; m_sq[k] <= 0;
            end else begin
                int a;
                a = exp_act(k);
                m_last[k] <= a;
                if (a != 3) begin
                    m_rw[k][1] <= m_rw[k][0];
                    m_da[k][1] <= m_da[k][0];
                    m_rw[k][0] <= (a == 0) ? s_rw : 1'b0;
                    m_da[k][0] <= (a == 0) ? s_da : 5'd0;
                end
                if (a == 1 && m_st[k] < MAXC[k]) m_st[k] <= m_st[k] + 1;
                if (a == 2 && m_sq[k] < MAXC[k]) m_sq[k] <= m_sq[k] + 1;
            end
        end
    end

    task automatic chk(input string nm, input int k, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s cfg%0d: got %0d expected %0d at %0t", nm, k, got, want, $time);
        end
    endtask

    // Every-cycle comparison against the model, sampled away from the clock edge
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                chk("ctl", k, 32'(ctl[k]), 32'(ctl_of(exp_act(k))));
                chk("last_action", k, la[k], m_last[k]);
                chk("stall_cnt", k, sc[k], m_st[k]);
                chk("squash_cnt", k, qc[k], m_sq[k]);
            end
        end
    end

    // Apply one DOF-stage vector just after the edge; return at the following negedge
    task automatic step(input int da, input int aa, input int ba, input bit rw,
                        input bit ma = 0, input bit mb = 0, input bit br = 0,
                        input bit busy = 0, input bit do_rst = 0);
        @(posedge clk);
        #1;
        s_da = 5'(da); s_aa = 5'(aa); s_ba = 5'(ba); s_rw = rw;
        s_ma = ma; s_mb = mb; s_br = br; s_busy = busy; rst = do_rst;
        @(negedge clk);
    endtask

    task automatic nop_step(input bit br = 0);
        step(0, 0, 0, 1'b0, 1'b0, 1'b0, br);
    endtask

    initial begin
        rst = 1'b1;
        s_da = 5'd0; s_aa = 5'd0; s_ba = 5'd0;
        s_rw = 1'b0; s_ma = 1'b0; s_mb = 1'b0; s_br = 1'b0; s_busy = 1'b0;
        @(posedge clk);
        #1 chk_en = 1'b1;
        nop_step();
        // Reset state
        chk("lit reset ctl", 0, 32'(ctl[0]), 0);
        chk("lit reset last", 0, la[0], 0);
        chk("lit reset stall", 0, sc[0], 0);

        // ADD R3<-R1,R2 ; SUB R4<-R3,R5 back to back
        step(3, 1, 2, 1'b1);
        step(4, 3, 5, 1'b1);
        chk("lit raw1 stall ctl", 0, 32'(ctl[0]), 32'h19);
        chk("lit raw1 bypass stall ctl", 1, 32'(ctl[1]), 32'h19);
        step(4, 3, 5, 1'b1);
        chk("lit raw2 stall ctl", 0, 32'(ctl[0]), 32'h19);
        chk("lit raw2 bypass run ctl", 1, 32'(ctl[1]), 0);
        chk("lit raw2 last", 0, la[0], 1);
        step(4, 3, 5, 1'b1);
        chk("lit raw run ctl", 0, 32'(ctl[0]), 0);
        chk("lit raw stall_cnt", 0, sc[0], 2);
        chk("lit raw bypass stall_cnt", 1, sc[1], 1);
        nop_step();

        // Write R0, then read R0 through A (B is a constant)
        step(0, 1, 2, 1'b1);
        step(5, 0, 0, 1'b1, 1'b0, 1'b1);
        chk("lit r0 zero ctl", 0, 32'(ctl[0]), 0);
        chk("lit r0 real ctl", 2, 32'(ctl[2]), 32'h19);
        step(5, 0, 0, 1'b1, 1'b0, 1'b1);
        step(5, 0, 0, 1'b1, 1'b0, 1'b1);
        chk("lit r0 real run ctl", 2, 32'(ctl[2]), 0);
        chk("lit r0 real stall_cnt", 2, sc[2], 4);
        chk("lit r0 zero stall_cnt", 0, sc[0], 2);

        // ADI ignores BA, JML ignores AA
        step(3, 1, 2, 1'b1);
        step(6, 1, 3, 1'b1, 1'b0, 1'b1);
        chk("lit adi ctl", 0, 32'(ctl[0]), 0);
        step(7, 6, 0, 1'b1, 1'b1, 1'b0);
        chk("lit jml ctl", 0, 32'(ctl[0]), 0);

        // Taken branch while DOF holds a hazarding instruction
        step(3, 1, 2, 1'b1);
        step(4, 3, 5, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("lit squash ctl", 0, 32'(ctl[0]), 32'h05);
        nop_step();
        chk("lit squash last", 0, la[0], 2);
        chk("lit squash_cnt", 0, qc[0], 1);
        chk("lit squash stall_cnt", 0, sc[0], 2);

        // Freeze for 3 cycles as the dependent instruction reaches DOF
        step(3, 1, 2, 1'b1);
        step(4, 3, 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("lit freeze ctl", 0, 32'(ctl[0]), 32'h1a);
        step(4, 3, 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("lit freeze last", 0, la[0], 3);
        step(4, 3, 5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("lit freeze+br ctl", 0, 32'(ctl[0]), 32'h1a);
        chk("lit freeze stall_cnt", 0, sc[0], 2);
        chk("lit freeze squash_cnt", 0, qc[0], 1);
        step(4, 3, 5, 1'b1);
        chk("lit post-freeze stall ctl", 0, 32'(ctl[0]), 32'h19);
        chk("lit post-freeze last", 0, la[0], 3);
        step(4, 3, 5, 1'b1);
        step(4, 3, 5, 1'b1);
        chk("lit post-freeze run ctl", 0, 32'(ctl[0]), 0);
        chk("lit post-freeze stall_cnt", 0, sc[0], 4);

        // Reset in the middle of a stall
        step(3, 1, 2, 1'b1);
        step(4, 3, 5, 1'b1);
        chk("lit pre-reset ctl", 0, 32'(ctl[0]), 32'h19);
        step(4, 3, 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(4, 3, 5, 1'b1);
        chk("lit post-reset ctl", 0, 32'(ctl[0]), 0);
        chk("lit post-reset stall_cnt", 0, sc[0], 0);
        chk("lit post-reset squash_cnt", 0, qc[0], 0);
        chk("lit post-reset last", 0, la[0], 0);

        // Counter saturation in the 3-bit configuration
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 2, 1'b1);
            for (int j = 0; j < 3; j++) step(5, 0, 0, 1'b1, 1'b0, 1'b1);
        end
        for (int i = 0; i < 9; i++) nop_step(1'b1);
        nop_step();
        chk("lit sat stall_cnt", 2, sc[2], 7);
        chk("lit sat squash_cnt", 2, qc[2], 7);
        chk("lit nosat squash_cnt", 0, qc[0], 9);
        chk("lit nosat stall_cnt", 0, sc[0], 0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline sequencing controller for the 4-stage pipelined RISC core (IF, DOF, EX, WB). It takes the DOF-stage instruction's decoded fields from the instruction decoder and tracks destination registers in flight in EX and WB, with no operand forwarding. From these it generates hold and NOP-insert controls for the PC and pipeline registers. It stalls on read-after-write hazards, squashes wrong-path instructions on taken branches and jumps, and freezes the whole pipeline while data memory is busy.

## Interface
- `WB_BYPASS`, default 0: 1 = register file write in WB is visible to a DOF read in the same cycle, so the WB stage is excluded from hazard compare.
- `ZERO_REG_EN`, default 1: 1 = R0 is hard-wired zero, so reads/writes of R0 never cause hazards.
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `DA` in 5: DOF-stage destination register.
- `AA` in 5: DOF-stage A source register.
- `BA` in 5: DOF-stage B source register.
- `RW` in 1: DOF-stage instruction writes the register file.
- `MA` in 1: 1 = A operand is PC, so AA is not read.
- `MB` in 1: 1 = B operand is constant, so BA is not read.
- `br_taken` in 1: EX-stage branch/jump taken this cycle.
- `mem_busy` in 1: data memory is not ready; freeze pipeline.
- `pc_hold` out 1: PC keeps its value.
- `ir_hold` out 1: IF/DOF register (IR) keeps its value.
- `ir_nop` out 1: IF/DOF register loads NOP (opcode 0).
- `ex_hold` out 1: DOF/EX and EX/WB registers keep their values.
- `ex_nop` out 1: DOF/EX register loads NOP (RW=0, MW=0, BS=0).
- `last_action` out 2: registered record of the previous cycle's action: 0 RUN, 1 STALL, 2 SQUASH, 3 FREEZE.
- `stall_cnt` out CNT_W: saturating count of STALL cycles.
- `squash_cnt` out CNT_W: saturating count of SQUASH cycles.

## Operation
- Scoreboard registers: `ex_rw`, `ex_da[4:0]`, `wb_rw`, `wb_da[4:0]`.
- Read flags:
  - `a_rd` = !MA && !(ZERO_REG_EN && AA==0).
  - `b_rd` = !MB && !(ZERO_REG_EN && BA==0).
- Stage match: `m(x)` = `x_rw && !(ZERO_REG_EN && x_da==0) && (x_da==src)`.
- `hazard` = `(a_rd && (m_ex(AA) || (!WB_BYPASS && m_wb(AA)))) || (b_rd && (same for BA))`.
- Action select, strict priority FREEZE > SQUASH > STALL > RUN:
  - FREEZE (mem_busy): pc_hold=ir_hold=ex_hold=1, ir_nop=ex_nop=0. Scoreboard unchanged.
  - SQUASH (br_taken): pc_hold=0 (PC loads target), ir_nop=1, ex_nop=1. Scoreboard: wb<=ex, ex<=0. A hazard in the same cycle is ignored because the DOF instruction is wrong-path.
  - STALL (hazard): pc_hold=ir_hold=1, ex_nop=1. Scoreboard: wb<=ex, ex<=0.
  - RUN: all controls 0. Scoreboard: wb<=ex, ex_rw<=RW, ex_da<=DA.
- Control outputs are combinational from the inputs and the scoreboard.
- Scoreboard, last_action and counters update on the clock edge.
- Counters: STALL increments stall_cnt and SQUASH increments squash_cnt. Both hold at 2^CNT_W−1. FREEZE and RUN change neither.

## Timing
- Reset (rst=1 at an edge): ex_rw=wb_rw=0, ex_da=wb_da=0, last_action=0, stall_cnt=squash_cnt=0.
  - Control outputs then read 0 unless inputs force otherwise.
  - Mid-operation reset discards in-flight scoreboard entries.
- Hazard latency: 0 cycles. Stall asserts in the same cycle the dependent instruction sits in DOF.
- RAW distance 1 (producer in EX): 2 stall cycles with WB_BYPASS=0, 1 with WB_BYPASS=1.
- RAW distance 2 (producer in WB): 1 stall cycle with WB_BYPASS=0, 0 with WB_BYPASS=1.
- Taken branch: exactly 1 SQUASH cycle. It kills 2 instructions: the one in IF via ir_nop and the one in DOF via ex_nop.
- A multi-cycle freeze preserves the hazard state. After freeze ends, stall resumes with the same remaining count.
- mem_busy and br_taken together: FREEZE is taken. br_taken must be held by EX until the freeze releases; EX is held.

## Test plan
- ADD R3←R1,R2, then SUB R4←R3,R5 back-to-back, WB_BYPASS=0 -> exactly 2 cycles of pc_hold=ir_hold=ex_nop=1, stall_cnt=2, then RUN.
- Same sequence, WB_BYPASS=1 -> 1 stall cycle, stall_cnt=1.
- Producer writes R0 (DA=0, RW=1), consumer reads AA=0, ZERO_REG_EN=1 -> no stall. With ZERO_REG_EN=0 -> 2-cycle stall.
- ADI R6 (MB=1) reading BA field=R3 right after a write to R3 -> no stall from B. JML (MA=1) with AA matching -> no stall from A.
- br_taken=1 while DOF holds a hazarding instruction -> ir_nop=ex_nop=1, pc_hold=0, last_action=2 next cycle, squash_cnt+1, stall_cnt unchanged.
- mem_busy=1 for 3 cycles during a 2-cycle stall -> 3 cycles of all holds with last_action=3, counters frozen. Then 2 stall cycles. Assert rst mid-stall -> scoreboard clear, outputs 0, counters 0.
